// File: rtl/sys_clkdiv_rstseq.sv
// Programmable clock-divider bank with an MMCM-lock-qualified peripheral
// reset sequencer. Every channel produces a registered square wave and a
// one-cycle tick per period. Divisors are double-buffered so that a change
// only takes effect at a period boundary.

// One divider channel: shadow/active divisor pair, phase counter and registered outputs.
module sys_clkdiv_ch #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_val,
    output logic             clk_div_o,
    output logic             tick_o
);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] n_cur, n_nxt;
    logic             run_q;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wrap, restart;

    // cnt_q is the phase currently shown on the outputs. A new period begins
    // (phase 0) on a wrap, on the first running cycle, or while stopped.
    // Only at that point may the active divisor pick up the shadow value, and
    // a load arriving on that same cycle bypasses straight through.
    always_comb begin
        shadow_d = div_load ? div_val : shadow_q;
        n_cur    = (active_q < DIV_MIN) ? DIV_MIN : active_q;
        wrap     = run_q && (cnt_q == n_cur - DIV_ONE);
        restart  = !run || !run_q || wrap;
        active_d = restart ? shadow_d : active_q;
        n_nxt    = (active_d < DIV_MIN) ? DIV_MIN : active_d;
        cnt_d    = restart ? '0 : cnt_q + DIV_ONE;
        clk_d    = run && (cnt_d < (n_nxt >> 1));
        tick_d   = run && (cnt_d == n_nxt - DIV_ONE);
    end

    // Channel state registers; reset reloads the default divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= DIV_RST;
            active_q <= DIV_RST;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            run_q    <= run;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
        end
    end

    assign clk_div_o = clk_q;
    assign tick_o    = tick_q;
endmodule

module sys_clkdiv_rstseq #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 256,
    parameter int RST_HOLD    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    locked,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*DIV_W-1:0] div_val,
    input  logic [NUM_CH-1:0]       div_load,
    output logic [NUM_CH-1:0]       clk_div_o,
    output logic [NUM_CH-1:0]       tick_o,
    output logic                    periph_rst_o,
    output logic [1:0]              seq_state_o
);
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        ST_ASSERT    = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_t;

    seq_state_t    state_q;
    logic [HW-1:0] hold_cnt_q;
    logic          periph_rst_q;
    logic          sync1_q, sync2_q;

    // Two-flop synchroniser for the asynchronous lock indication.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= locked;
            sync2_q <= sync1_q;
        end
    end

    // Reset sequencer: release the peripheral reset only after the lock has been stable for RST_HOLD cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ASSERT;
            hold_cnt_q   <= '0;
            periph_rst_q <= 1'b1;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    state_q      <= ST_WAIT_LOCK;
                    periph_rst_q <= 1'b1;
                end
                ST_WAIT_LOCK: begin
                    hold_cnt_q   <= '0;
                    periph_rst_q <= 1'b1;
                    if (sync2_q) state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!sync2_q) begin
                        state_q      <= ST_WAIT_LOCK;
                        hold_cnt_q   <= '0;
                        periph_rst_q <= 1'b1;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_q      <= ST_RUN;
                        periph_rst_q <= 1'b0;
                    end else begin
                        hold_cnt_q   <= hold_cnt_q + 1'b1;
                        periph_rst_q <= 1'b1;
                    end
                end
                default: begin
                    if (!sync2_q) begin
                        state_q      <= ST_WAIT_LOCK;
                        periph_rst_q <= 1'b1;
                    end else begin
                        periph_rst_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign periph_rst_o = periph_rst_q;
    assign seq_state_o  = state_q;

    // Divider channels run only when enabled and the peripherals are out of reset.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sys_clkdiv_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .run       (ch_en[i] & ~periph_rst_q),
            .div_load  (div_load[i]),
            .div_val   (div_val[i*DIV_W +: DIV_W]),
            .clk_div_o (clk_div_o[i]),
            .tick_o    (tick_o[i])
        );
    end
endmodule

// File: tb/tb_sys_clkdiv_rstseq.sv
// Directed bench for sys_clkdiv_rstseq: reset sequencing table plus
// hand-written divider, divisor-update and lock-loss sequences.
module tb_sys_clkdiv_rstseq;
    localparam int NUM_CH = 4;
    localparam int DIV_W  = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    locked;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH*DIV_W-1:0] div_val;
    logic [NUM_CH-1:0]       div_load;
    logic [NUM_CH-1:0]       clk_div_o;
    logic [NUM_CH-1:0]       tick_o;
    logic                    periph_rst_o;
    logic [1:0]              seq_state_o;

    int n_chk  = 0;
    int n_fail = 0;

    sys_clkdiv_rstseq #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(256), .RST_HOLD(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .locked       (locked),
        .ch_en        (ch_en),
        .div_val      (div_val),
        .div_load     (div_load),
        .clk_div_o    (clk_div_o),
        .tick_o       (tick_o),
        .periph_rst_o (periph_rst_o),
        .seq_state_o  (seq_state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ncyc;
        logic       lck;
        logic [3:0] en;
        logic [1:0] st;
        logic       prst;
        logic [3:0] cd;
        logic [3:0] tk;
    } vec_t;

    vec_t vt[5];

    // Expected per-cycle waveforms, element 1 is the first sample.
    logic [1:18] e1c, e1t, e2c, e2t;
    logic [1:5]  r1c, r1t, r2c, r2t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic load(input int ch, input logic [DIV_W-1:0] v);
        div_val[ch*DIV_W +: DIV_W] = v;
        div_load     = '0;
        div_load[ch] = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int highs, ticks_a, ticks_b, cnt;
        logic [1:0] exp_st;

        vt[0] = '{1,  1'b1, 4'h0, 2'd1, 1'b1, 4'h0, 4'h0};
        vt[1] = '{1,  1'b1, 4'h0, 2'd1, 1'b1, 4'h0, 4'h0};
        vt[2] = '{1,  1'b1, 4'hF, 2'd2, 1'b1, 4'h0, 4'h0};
        vt[3] = '{15, 1'b1, 4'hF, 2'd2, 1'b1, 4'h0, 4'h0};
        vt[4] = '{1,  1'b1, 4'h0, 2'd3, 1'b0, 4'h0, 4'h0};

        e1c = 18'b11110000_11000_11000;
        e1t = 18'b00000001_00001_00001;
        e2c = 18'b1100_100100_1010_1010;
        e2t = 18'b0001_001001_0101_0101;
        r1c = 5'b11000;
        r1t = 5'b00001;
        r2c = 5'b10101;
        r2t = 5'b01010;

        rst = 1'b1; locked = 1'b1; ch_en = '0; div_load = '0; div_val = '0;
        repeat (4) step();
        chk("rst_clk_div", clk_div_o, 4'h0);
        chk("rst_tick", tick_o, 4'h0);
        chk("rst_periph_rst", periph_rst_o, 1'b1);
        chk("rst_state", seq_state_o, 2'd0);
        rst = 1'b0;

        // Sequencer release: periph_rst falls 19 cycles after rst release.
        for (int i = 0; i < 5; i++) begin
            locked = vt[i].lck;
            ch_en  = vt[i].en;
            repeat (vt[i].ncyc) step();
            chk($sformatf("seq%0d_state", i), seq_state_o, vt[i].st);
            chk($sformatf("seq%0d_prst", i), periph_rst_o, vt[i].prst);
            chk($sformatf("seq%0d_clk", i), clk_div_o, vt[i].cd);
            chk($sformatf("seq%0d_tick", i), tick_o, vt[i].tk);
        end

        // Channel 0 at the default divisor of 256.
        ch_en = 4'b0001;
        highs = 0; ticks_a = 0; ticks_b = 0;
        for (int k = 1; k <= 512; k++) begin
            step();
            if (k <= 256) highs += int'(clk_div_o[0]);
            if (k <= 255) ticks_a += int'(tick_o[0]);
            if (k >= 257 && k <= 511) ticks_b += int'(tick_o[0]);
            if (k == 1)   chk("ch0_first_high", clk_div_o[0], 1'b1);
            if (k == 128) chk("ch0_high_end", clk_div_o[0], 1'b1);
            if (k == 129) chk("ch0_low_start", clk_div_o[0], 1'b0);
            if (k == 256) chk("ch0_tick1", tick_o[0], 1'b1);
            if (k == 257) chk("ch0_period2_high", clk_div_o[0], 1'b1);
            if (k == 512) chk("ch0_tick2", tick_o[0], 1'b1);
        end
        chk("ch0_high_cycles", highs, 128);
        chk("ch0_early_ticks", ticks_a, 0);
        chk("ch0_mid_ticks", ticks_b, 0);

        // Channel 1: N=8, reload to 5 in mid-period.
        load(1, 16'd8);
        step();
        div_load = '0;
        ch_en[1] = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            div_load = '0;
            chk($sformatf("ch1_clk_k%0d", k), clk_div_o[1], e1c[k]);
            chk($sformatf("ch1_tick_k%0d", k), tick_o[1], e1t[k]);
            if (k == 3) load(1, 16'd5);
        end

        // Channel 2: loads on the wrap cycle take effect immediately; N=0/1 act as 2.
        load(2, 16'd4);
        step();
        div_load = '0;
        ch_en[2] = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            div_load = '0;
            chk($sformatf("ch2_clk_k%0d", k), clk_div_o[2], e2c[k]);
            chk($sformatf("ch2_tick_k%0d", k), tick_o[2], e2t[k]);
            if (k == 4)  load(2, 16'd3);
            if (k == 10) load(2, 16'd0);
            if (k == 14) load(2, 16'd1);
        end

        // Enable drop and re-enable on channel 2.
        step();
        chk("ch2_pre_drop_clk", clk_div_o[2], 1'b1);
        ch_en[2] = 1'b0;
        step();
        chk("ch2_drop_clk", clk_div_o[2], 1'b0);
        chk("ch2_drop_tick", tick_o[2], 1'b0);
        ch_en[2] = 1'b1;
        step();
        chk("ch2_reen_clk", clk_div_o[2], 1'b1);
        chk("ch2_reen_tick", tick_o[2], 1'b0);
        step();
        chk("ch2_reen_clk2", clk_div_o[2], 1'b0);
        chk("ch2_reen_tick2", tick_o[2], 1'b1);

        // Lock loss for 3 cycles while running.
        locked = 1'b0;
        step();
        chk("lol_prst_a0", periph_rst_o, 1'b0);
        step();
        step();
        chk("lol_prst_a2", periph_rst_o, 1'b1);
        chk("lol_state_a2", seq_state_o, 2'd1);
        locked = 1'b1;
        step();
        chk("lol_clk_frozen", clk_div_o, 4'h0);
        chk("lol_tick_frozen", tick_o, 4'h0);
        cnt = 1;
        while (periph_rst_o && cnt < 40) begin
            step();
            cnt++;
        end
        chk("relock_latency", cnt, 19);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("relock_ch1_clk_k%0d", k), clk_div_o[1], r1c[k]);
            chk($sformatf("relock_ch1_tick_k%0d", k), tick_o[1], r1t[k]);
            chk($sformatf("relock_ch2_clk_k%0d", k), clk_div_o[2], r2c[k]);
            chk($sformatf("relock_ch2_tick_k%0d", k), tick_o[2], r2t[k]);
            if (k == 1) chk("relock_ch0_clk", clk_div_o[0], 1'b1);
        end

        // Glitch on locked during HOLD restarts the hold window.
        locked = 1'b0;
        repeat (3) step();
        locked = 1'b1;
        for (int j = 0; j <= 29; j++) begin
            step();
            if (j <= 1 || j == 12) exp_st = 2'd1;
            else if (j == 29)      exp_st = 2'd3;
            else                   exp_st = 2'd2;
            chk($sformatf("glitch_state_j%0d", j), seq_state_o, exp_st);
            chk($sformatf("glitch_prst_j%0d", j), periph_rst_o, (j < 29) ? 1'b1 : 1'b0);
            locked = (j == 9) ? 1'b0 : 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
